// File: rtl/cpu_mon_pkg.sv
// Shared types and constants for the CPU result monitor: FSM states,
// store-size encodings and the verdict flag bundle.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } mon_state_e;

  localparam logic [1:0] MODE_B   = 2'b00;
  localparam logic [1:0] MODE_H   = 2'b01;
  localparam logic [1:0] MODE_W   = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef struct packed {
    logic timeout;
    logic fail;
    logic pass;
  } verdict_t;

  localparam verdict_t VERDICT_NONE    = '{timeout: 1'b0, fail: 1'b0, pass: 1'b0};
  localparam verdict_t VERDICT_PASS    = '{timeout: 1'b0, fail: 1'b0, pass: 1'b1};
  localparam verdict_t VERDICT_FAIL    = '{timeout: 1'b0, fail: 1'b1, pass: 1'b0};
  localparam verdict_t VERDICT_TIMEOUT = '{timeout: 1'b1, fail: 1'b0, pass: 1'b0};

  // Number of bytes written by a store of the given size; reserved writes none.
  function automatic logic [2:0] mode_bytes(input logic [1:0] m);
    case (m)
      MODE_B:  return 3'd1;
      MODE_H:  return 3'd2;
      MODE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic verdict_t state_verdict(input mon_state_e st);
    case (st)
      ST_PASS:    return VERDICT_PASS;
      ST_FAIL:    return VERDICT_FAIL;
      ST_TIMEOUT: return VERDICT_TIMEOUT;
      default:    return VERDICT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pc_stall_det.sv
// Halt detector: flags a program halt once the PC has stayed unchanged for
// HALT_CYCLES consecutive enabled edges; halt is a same-cycle pulse.
module pc_stall_det #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned HALT_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halt
);

  localparam int unsigned  S_W    = $clog2(HALT_CYCLES + 1);
  localparam logic [S_W-1:0] S_MAX  = '1;
  localparam logic [S_W-1:0] S_HALT = S_W'(HALT_CYCLES - 1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [S_W-1:0]      s_q, s_d;
  logic                same;

  assign same = (pc == pc_q);
  assign halt = en && same && (s_q == S_HALT);

  always_comb begin
    pc_d = pc_q;
    s_d  = s_q;
    if (en) begin
      pc_d = pc;
      if (!same) begin
        s_d = '0;
      end else if (s_q != S_MAX) begin
        s_d = s_q + S_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      s_q  <= '0;
    end else begin
      pc_q <= pc_d;
      s_q  <= s_d;
    end
  end

endmodule

// File: rtl/cpu_result_mon.sv
// Snoops core stores into a shadow copy of the result word and issues a
// sticky PASS/FAIL/TIMEOUT verdict once the program halts or runs too long.
module cpu_result_mon
  import cpu_mon_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STORE_M        = 2,
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR = 'h08,
  parameter logic [31:0] PASS_VALUE     = 32'h0000_0001,
  parameter int unsigned HALT_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  wr_en,
  input  logic [STORE_M-1:0]    mode,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [31:0]           result,
  output logic [3:0]            byte_valid,
  output logic                  result_valid,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout
);

  localparam int unsigned      NLANE   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

  mon_state_e            state_q, state_d;
  logic [31:0]           result_q, result_d;
  logic [NLANE-1:0]      bv_q, bv_d;
  logic                  rv_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  verdict_t              verdict_q;
  logic                  run;
  logic                  halt;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH-1:0] baddr;
  logic [ADDR_WIDTH-1:0] off;

  assign run = (state_q == ST_RUN);

  pc_stall_det #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_stall (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .pc   (pc),
    .halt (halt)
  );

  // Store merge, cycle counting and verdict decision; frozen outside RUN.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    bv_d     = bv_q;
    cnt_d    = cnt_q;
    nbytes   = mode_bytes(2'(mode));
    baddr    = '0;
    off      = '0;
    if (run) begin
      if (wr_en) begin
        for (int k = 0; k < NLANE; k++) begin
          if (3'(k) < nbytes) begin
            baddr = wr_addr + ADDR_WIDTH'(k);
            off   = baddr - RESULT_ADDR;
            if (off < ADDR_WIDTH'(NLANE)) begin
              result_d[8*off[1:0] +: 8] = wr_data[8*k +: 8];
              bv_d[off[1:0]]            = 1'b1;
            end
          end
        end
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (halt) begin
        state_d = ((&bv_d) && (result_d == PASS_VALUE)) ? ST_PASS : ST_FAIL;
      end else if (cnt_d == CNT_TO) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      result_q  <= '0;
      bv_q      <= '0;
      rv_q      <= 1'b0;
      cnt_q     <= '0;
      verdict_q <= VERDICT_NONE;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      bv_q      <= bv_d;
      rv_q      <= &bv_d;
      cnt_q     <= cnt_d;
      verdict_q <= state_verdict(state_d);
    end
  end

  assign result       = result_q;
  assign byte_valid   = bv_q;
  assign result_valid = rv_q;
  assign cycle_cnt    = cnt_q;
  assign pass         = verdict_q.pass;
  assign fail         = verdict_q.fail;
  assign timeout      = verdict_q.timeout;
  assign done         = |verdict_q;

endmodule

// File: tb/tb_cpu_result_mon.sv
// Directed bench for cpu_result_mon: store merging, halt verdicts, timeout
// boundary, freeze after verdict and reset behaviour.
module tb_cpu_result_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic        wr_en;
  logic [1:0]  mode;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] result;
  logic [3:0]  byte_valid;
  logic        result_valid;
  logic [15:0] cycle_cnt;
  logic        done, pass, fail, timeout;
  logic [3:0]  flags;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign flags = {done, pass, fail, timeout};

  cpu_result_mon #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .wr_en        (wr_en),
    .mode         (mode),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .result       (result),
    .byte_valid   (byte_valid),
    .result_valid (result_valid),
    .cycle_cnt    (cycle_cnt),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    mode    = 2'b00;
    wr_addr = 8'h00;
    wr_data = 32'h0;
  endtask

  task automatic store(input logic [1:0] m, input logic [7:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    mode    = m;
    wr_addr = a;
    wr_data = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc  = 8'h00;
    idle();
    tick();
    chk("rst_result", result, 32'h0);
    chk("rst_bv", 32'(byte_valid), 32'h0);
    chk("rst_rv", 32'(result_valid), 32'h0);
    chk("rst_cnt", 32'(cycle_cnt), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    rst = 1'b0;

    // Word store of the pass value, then a PC self-loop.
    pc = 8'h01;
    store(2'b10, 8'h08, 32'h0000_0001);
    chk("w_result", result, 32'h0000_0001);
    chk("w_bv", 32'(byte_valid), 32'hF);
    chk("w_rv", 32'(result_valid), 32'h1);
    chk("w_cnt", 32'(cycle_cnt), 32'd1);
    pc = 8'h20;
    repeat (8) tick();
    chk("pre_halt_flags", 32'(flags), 32'h0);
    tick();
    chk("pass_flags", 32'(flags), 32'b1100);
    chk("pass_cnt", 32'(cycle_cnt), 32'd10);

    // Verdict is sticky; later stores and PC motion are ignored.
    pc = 8'h21;
    store(2'b10, 8'h08, 32'hDEAD_BEEF);
    pc = 8'h22;
    tick();
    chk("frz_result", result, 32'h0000_0001);
    chk("frz_flags", 32'(flags), 32'b1100);
    chk("frz_cnt", 32'(cycle_cnt), 32'd10);

    // One-cycle reset with a concurrent store discards the store.
    rst     = 1'b1;
    wr_en   = 1'b1;
    mode    = 2'b10;
    wr_addr = 8'h08;
    wr_data = 32'h5555_5555;
    tick();
    rst = 1'b0;
    idle();
    chk("rst2_result", result, 32'h0);
    chk("rst2_bv", 32'(byte_valid), 32'h0);
    chk("rst2_rv", 32'(result_valid), 32'h0);
    chk("rst2_cnt", 32'(cycle_cnt), 32'h0);
    chk("rst2_flags", 32'(flags), 32'h0);
    tick();
    chk("rst2_after_result", result, 32'h0);
    chk("rst2_after_cnt", 32'(cycle_cnt), 32'd1);

    // Single byte only: result incomplete, so the halt verdict is FAIL.
    do_reset();
    pc = 8'h01;
    store(2'b00, 8'h08, 32'h0000_0001);
    pc = 8'h30;
    repeat (9) tick();
    chk("b_bv", 32'(byte_valid), 32'h1);
    chk("b_rv", 32'(result_valid), 32'h0);
    chk("b_result", result, 32'h0000_0001);
    chk("b_flags", 32'(flags), 32'b1010);

    // Two halves build a complete but wrong result.
    do_reset();
    pc = 8'h01;
    store(2'b01, 8'h0A, 32'h0000_BEEF);
    chk("h_upper_bv", 32'(byte_valid), 32'hC);
    pc = 8'h02;
    store(2'b01, 8'h08, 32'h0000_0001);
    chk("h_result", result, 32'hBEEF_0001);
    chk("h_bv", 32'(byte_valid), 32'hF);
    pc = 8'h40;
    repeat (9) tick();
    chk("h_flags", 32'(flags), 32'b1010);

    // Misaligned word straddles into lanes 0/1; reserved and outside stores do nothing.
    do_reset();
    pc = 8'h01;
    store(2'b10, 8'h06, 32'hAABB_CCDD);
    chk("mis_result", result, 32'h0000_AABB);
    chk("mis_bv", 32'(byte_valid), 32'h3);
    pc = 8'h02;
    store(2'b11, 8'h08, 32'hFFFF_FFFF);
    chk("rsv_result", result, 32'h0000_AABB);
    chk("rsv_bv", 32'(byte_valid), 32'h3);
    pc = 8'h03;
    store(2'b10, 8'h0C, 32'h1234_5678);
    chk("out_result", result, 32'h0000_AABB);
    pc = 8'h04;
    store(2'b00, 8'h0B, 32'h0000_0077);
    chk("lane3_result", result, 32'h7700_AABB);
    chk("lane3_bv", 32'(byte_valid), 32'hB);

    // PC keeps moving: timeout on exactly the 100th RUN edge.
    do_reset();
    for (int i = 1; i <= 99; i++) begin
      pc = 8'(i);
      tick();
    end
    chk("to_pre_flags", 32'(flags), 32'h0);
    chk("to_pre_cnt", 32'(cycle_cnt), 32'd99);
    pc = 8'd100;
    tick();
    chk("to_flags", 32'(flags), 32'b1001);
    chk("to_cnt", 32'(cycle_cnt), 32'd100);
    pc = 8'd101;
    store(2'b10, 8'h08, 32'h0000_0001);
    pc = 8'd102;
    tick();
    chk("to_frz_cnt", 32'(cycle_cnt), 32'd100);
    chk("to_frz_result", result, 32'h0);
    chk("to_frz_flags", 32'(flags), 32'b1001);

    // Halt lands on the timeout edge, with a same-edge store deciding PASS.
    do_reset();
    for (int i = 1; i <= 92; i++) begin
      pc = 8'(i);
      tick();
    end
    repeat (7) tick();
    chk("ht_pre_flags", 32'(flags), 32'h0);
    chk("ht_pre_cnt", 32'(cycle_cnt), 32'd99);
    store(2'b10, 8'h08, 32'h0000_0001);
    chk("ht_flags", 32'(flags), 32'b1100);
    chk("ht_cnt", 32'(cycle_cnt), 32'd100);
    chk("ht_result", result, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_result_mon.md
# cpu_result_mon

Simulation-side result monitor that sits downstream of the `rv32i` core's data-store port, in parallel with `d_mem`. It snoops every store and keeps a shadow copy of the 32-bit little-endian result word at `RESULT_ADDR`. It detects program halt as a self-loop on `pc`, then issues a sticky PASS/FAIL/TIMEOUT verdict. Benches read the verdict from this block instead of peeking into `d_mem` internals after a fixed cycle count.

## Interface
- `ADDR_WIDTH`, 8: data address width.
- `PC_WIDTH`, 8: PC width.
- `DATA_W`, 32: store data width.
- `STORE_M`, 2: mode width.
- `RESULT_ADDR`, 8'h08: byte address of result word (lanes at +0..+3).
- `PASS_VALUE`, 32'h0000_0001: result value that means pass.
- `HALT_CYCLES`, 8: consecutive unchanged-PC edges that count as a halt (≥2).
- `TIMEOUT_CYCLES`, 1000: RUN-cycle budget.
- `CNT_W`, 16: cycle counter width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  PC_WIDTH  core PC.
- `wr_en`  in  1  store strobe.
- `mode`  in  STORE_M  store size: 00 byte, 01 half, 10 word, 11 reserved.
- `wr_addr`  in  ADDR_WIDTH  store byte address.
- `wr_data`  in  DATA_W  store data, LSB-aligned.
- `result`  out  32  shadow result word.
- `byte_valid`  out  4  per-lane written flags.
- `result_valid`  out  1  `&byte_valid`.
- `cycle_cnt`  out  CNT_W  edges spent in RUN.
- `done`, `pass`, `fail`, `timeout`  out  1 each  sticky verdict flags.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and are left only by `rst`.
- Store merge (RUN only, `wr_en`=1, mode≠11):
  - A store writes bytes `wr_addr+k` for k < 1/2/4. Address arithmetic is modulo 2^ADDR_WIDTH.
  - Each written byte whose address lies in RESULT_ADDR..+3 updates lane `addr-RESULT_ADDR` with `wr_data[8k+7:8k]` and sets that lane's `byte_valid` bit.
  - Misaligned stores are merged byte by byte.
  - Mode 11 is ignored.
- Halt detect:
  - Registers `pc_q` and a saturating stall counter `s`.
  - Each RUN edge: `s` ← (`pc`==`pc_q`) ? `s`+1 : 0; `pc_q` ← `pc`.
  - A halt fires on the edge where `pc`==`pc_q` and `s`==HALT_CYCLES-1.
- Verdict on halt:
  - Evaluated on the merged result, including any store on the same edge.
  - PASS if `result_valid` and the merged result equals PASS_VALUE; otherwise FAIL.
- Timeout: `cycle_cnt` increments on every RUN edge. If the incremented value equals TIMEOUT_CYCLES and no halt fires on that edge, the FSM goes to TIMEOUT.
- Simultaneous halt and timeout: halt wins.
- Terminal states freeze `result`, `byte_valid` and `cycle_cnt`. Later stores and PC motion are ignored.

## Timing
- All outputs are registered. A store at edge N is visible on `result` after edge N.
- The verdict flags assert after the deciding edge. `done` = PASS|FAIL|TIMEOUT; exactly one of `pass`/`fail`/`timeout` is high with it.
- Reset values: `result`=0, `byte_valid`=0, `result_valid`=0, `cycle_cnt`=0, all flags 0, state RUN, `pc_q`=0, `s`=0.
- A store or PC sample on an edge where `rst`=1 is discarded.
- Reset mid-run or after a verdict returns everything to reset values on that edge. Monitoring restarts on the first edge with `rst`=0.
- `cycle_cnt` saturates at 2^CNT_W-1. TIMEOUT_CYCLES must fit in CNT_W.

## Structure
- Shared package `cpu_mon_pkg`:
  - state enum;
  - mode encodings MODE_B/MODE_H/MODE_W/MODE_RSV;
  - verdict constants.
- The halt-detect logic is one sub-module, `pc_stall_det`, which holds `pc_q` and `s` and emits a single-cycle `halt` pulse with an `en` input.
- Store merge, cycle counter and FSM live in the top module.

## Test plan
- Word store 0x00000001 at 0x08, then `pc` held at 0x20 → 8 edges after `pc` reaches 0x20: `pass`=`done`=1, `result`=0x00000001, `byte_valid`=1111.
- Byte store 0x01 at 0x08 only, then halt → `byte_valid`=0001, `result_valid`=0, `fail`=1.
- Half store 0xBEEF at 0x0A, then half 0x0001 at 0x08, then halt → `result`=0xBEEF0001, `fail`=1.
- Misaligned word store 0xAABBCCDD at 0x06 → lane0=0xBB, lane1=0xAA, `byte_valid`=0011. Mode-11 store at 0x08 → no change.
- `pc` increments every edge, TIMEOUT_CYCLES=100 → `timeout`=1 after the 100th RUN edge, `cycle_cnt`=100, then frozen. With halt landing on the same edge → PASS or FAIL, not TIMEOUT.
- After PASS, later stores and PC motion leave `result` and flags unchanged. A one-cycle `rst` with a concurrent store clears every output to its reset value, and the discarded store does not appear.
